// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - polyphonic square-wave tone synthesizer with PWM audio output
// Each voice runs its own half-period divider and tick-based duration; voices are summed into one PWM stream.
module tone_synth #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int VOL_W    = 4,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 100000,
  localparam int CH_W    = $clog2(NUM_CH),
  localparam int PWM_W   = VOL_W + CH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_half_period,
  input  logic [VOL_W-1:0]  wr_volume,
  input  logic [DUR_W-1:0]  wr_duration,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] note_done,
  output logic              AUD_PWM,
  output logic              AUD_SD
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic [PWM_W-1:0] carrier_q;
  logic [PWM_W-1:0] level_q;
  logic [PWM_W-1:0] sample;
  logic [NUM_CH-1:0] active;
  logic [VOL_W-1:0] contrib [NUM_CH];

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  // The prescaler runs freely so note lengths are quantised to the global tick grid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
    logic [DIV_W-1:0] half_period_q;
    logic [DIV_W-1:0] count_q;
    logic [VOL_W-1:0] volume_q;
    logic [DUR_W-1:0] remaining_q;
    logic             toggle_q;
    logic             active_q;
    logic             done_q;
    logic             wr_hit;
    logic             expire;

    assign wr_hit = wr_en && (wr_ch == CH_W'(i));
    assign expire = active_q && tick && (remaining_q == DUR_W'(1));

    // A write in the expiry cycle retriggers the voice and swallows the note_done.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        half_period_q <= '0;
        count_q       <= '0;
        volume_q      <= '0;
        remaining_q   <= '0;
        toggle_q      <= 1'b0;
        active_q      <= 1'b0;
        done_q        <= 1'b0;
      end else begin
        done_q <= expire && !wr_hit;
        if (wr_hit) begin
          half_period_q <= wr_half_period;
          volume_q      <= wr_volume;
          remaining_q   <= wr_duration;
          count_q       <= '0;
          toggle_q      <= 1'b0;
          active_q      <= (wr_duration != '0);
        end else if (expire) begin
          remaining_q <= '0;
          count_q     <= '0;
          toggle_q    <= 1'b0;
          active_q    <= 1'b0;
        end else if (active_q) begin
          if (tick) begin
            remaining_q <= remaining_q - DUR_W'(1);
          end
          if (half_period_q != '0) begin
            if (count_q == half_period_q - DIV_W'(1)) begin
              count_q  <= '0;
              toggle_q <= ~toggle_q;
            end else begin
              count_q <= count_q + DIV_W'(1);
            end
          end
        end
      end
    end

    assign active[i]    = active_q;
    assign note_done[i] = done_q;
    assign contrib[i]   = (active_q && toggle_q) ? volume_q : '0;
  end

  always_comb begin
    sample = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sample = sample + PWM_W'(contrib[i]);
    end
  end

  // Level is only updated at the frame boundary so each PWM frame has a stable duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carrier_q <= '0;
      level_q   <= '0;
      AUD_PWM   <= 1'b0;
      AUD_SD    <= 1'b0;
    end else begin
      carrier_q <= carrier_q + PWM_W'(1);
      if (carrier_q == '1) begin
        level_q <= sample;
      end
      AUD_PWM <= (carrier_q < level_q);
      AUD_SD  <= |active;
    end
  end

  assign busy = active;

endmodule

// File: tb/tb_tone_synth.sv
// tb/tb_tone_synth.sv - self-checking bench for tone_synth against a time-arithmetic reference model
module tb_tone_synth;

  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 16;
  localparam int VOL_W    = 4;
  localparam int DUR_W    = 12;
  localparam int TICK_DIV = 10;
  localparam int FRAME    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [DIV_W-1:0]  wr_half_period = '0;
  logic [VOL_W-1:0]  wr_volume = '0;
  logic [DUR_W-1:0]  wr_duration = '0;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] note_done;
  logic              AUD_PWM;
  logic              AUD_SD;

  tone_synth #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .VOL_W(VOL_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_half_period(wr_half_period), .wr_volume(wr_volume), .wr_duration(wr_duration),
    .busy(busy), .note_done(note_done), .AUD_PWM(AUD_PWM), .AUD_SD(AUD_SD)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each voice is a note record (start edge, half-period, volume, expiry edge);
  // outputs after edge n are derived arithmetically from n.
  int n;
  bit m_valid [NUM_CH];
  int m_hp    [NUM_CH];
  int m_vol   [NUM_CH];
  int m_k     [NUM_CH];
  int m_exp   [NUM_CH];
  int level_m;
  int prev_sample;
  bit prev_any;
  logic [NUM_CH-1:0] e_busy;
  logic [NUM_CH-1:0] e_done;
  logic e_pwm;
  logic e_sd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    n = -1;
    for (int c = 0; c < NUM_CH; c++) m_valid[c] = 1'b0;
    level_m = 0;
    prev_sample = 0;
    prev_any = 1'b0;
  endtask

  task automatic model_edge();
    int sample;
    bit any;
    int t1;
    int c;
    n++;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_done[ch] = 1'b0;
      if (m_valid[ch] && m_exp[ch] == n) begin
        m_valid[ch] = 1'b0;
        if (!(wr_en && int'(wr_ch) == ch)) e_done[ch] = 1'b1;
      end
    end
    if (wr_en) begin
      c = int'(wr_ch);
      m_hp[c]    = int'(wr_half_period);
      m_vol[c]   = int'(wr_volume);
      m_k[c]     = n;
      m_valid[c] = (wr_duration != 0);
      t1 = (n / TICK_DIV) * TICK_DIV + TICK_DIV - 1;
      if (t1 <= n) t1 += TICK_DIV;
      m_exp[c] = t1 + (int'(wr_duration) - 1) * TICK_DIV;
    end
    sample = 0;
    any = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e_busy[ch] = m_valid[ch];
      any |= m_valid[ch];
      if (m_valid[ch] && m_hp[ch] != 0 && (((n - m_k[ch]) / m_hp[ch]) % 2) == 1)
        sample += m_vol[ch];
    end
    e_pwm = ((n % FRAME) < level_m);
    if ((n % FRAME) == FRAME - 1) level_m = prev_sample;
    prev_sample = sample;
    e_sd = prev_any;
    prev_any = any;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("note_done", 32'(note_done), 32'(e_done));
    chk("aud_pwm", 32'(AUD_PWM), 32'(e_pwm));
    chk("aud_sd", 32'(AUD_SD), 32'(e_sd));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic write(input int ch, input int hp, input int vol, input int dur);
    wr_en = 1'b1;
    wr_ch = 2'(ch);
    wr_half_period = DIV_W'(hp);
    wr_volume = VOL_W'(vol);
    wr_duration = DUR_W'(dur);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(note_done), 32'h0);
    chk({tag, "_pwm"}, 32'(AUD_PWM), 32'h0);
    chk({tag, "_sd"}, 32'(AUD_SD), 32'h0);
  endtask

  // Reset is raised between edges so the asynchronous clear is observable before any clock.
  task automatic do_reset();
    wr_en = 1'b0;
    #2 reset = 1'b1;
    #1 check_idle("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_hold");
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int guard;
    model_reset();
    @(negedge clk);
    do_reset();

    // single voice: toggle period 10, three ticks of duration
    write(0, 5, 15, 3);
    run(40);

    // full mix of four voices at near-identical phase
    write(0, 40, 15, 100);
    write(1, 40, 15, 100);
    write(2, 40, 15, 100);
    write(3, 40, 15, 100);
    run(300);

    // reset in the middle of sounding notes, then stay silent
    do_reset();
    run(20);

    // collision: rewrite ch1 on the very edge its note would expire
    write(1, 3, 7, 1);
    guard = 0;
    while (n + 1 < m_exp[1] && guard < 100) begin
      cycle();
      guard++;
    end
    chk("coll_guard", 32'(guard < 100), 32'h1);
    write(1, 4, 9, 2);
    chk("coll_busy", 32'(busy[1]), 32'h1);
    chk("coll_done", 32'(note_done[1]), 32'h0);
    run(30);

    // rest note: busy and amplifier on, silent output
    write(2, 0, 15, 2);
    chk("rest_busy", 32'(busy[2]), 32'h1);
    run(30);

    // cancel a playing voice
    write(3, 6, 10, 50);
    run(15);
    write(3, 6, 10, 0);
    chk("cancel_busy", 32'(busy[3]), 32'h0);
    run(5);
    chk("cancel_sd", 32'(AUD_SD), 32'h0);

    // randomized writes, including hp=1, rests, cancels and retriggers
    for (int i = 0; i < 60; i++) begin
      run($urandom_range(0, 25));
      write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 12),
            $urandom_range(0, 15), $urandom_range(0, 4));
    end
    run(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tone_synth.md
# tone_synth

Polyphonic successor to the fixed-frequency tone generator that drives the board audio output. NUM_CH independent square-wave voices each have a programmable half-period, volume and note duration. A 1 ms-style tick prescaler times the notes, and the voices are summed and rendered as a single PWM bitstream on AUD_PWM. AUD_SD gates the audio amplifier so it is enabled only while any voice is playing.

## Interface
- NUM_CH, 4: number of voices; must be ≥2. CH_W = clog2(NUM_CH).
- DIV_W, 16: half-period register width, in clocks.
- VOL_W, 4: per-voice volume width.
- DUR_W, 12: note duration width, in ticks.
- TICK_DIV, 100000: clocks per duration tick (1 ms at 100 MHz).
- PWM_W: derived localparam, VOL_W + CH_W. Mixer and carrier width.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- wr_en  in  1  load note into voice wr_ch this cycle
- wr_ch  in  CH_W  target voice
- wr_half_period  in  DIV_W  half-period in clocks; 0 = rest
- wr_volume  in  VOL_W  voice amplitude
- wr_duration  in  DUR_W  note length in ticks; 0 = cancel voice
- busy  out  NUM_CH  per-voice active flag
- note_done  out  NUM_CH  one-cycle pulse when a voice's note expires naturally
- AUD_PWM  out  1  PWM audio bitstream
- AUD_SD  out  1  amplifier enable, 1 = on

## Operation
- **Reset.** All state clears: prescaler, carrier, latched level, every voice's counter, toggle, active and remaining fields. busy=0, note_done=0, AUD_PWM=0, AUD_SD=0.
- **Write.** When wr_en=1, voice wr_ch loads half_period, volume and remaining=wr_duration, and sets phase counter=0 and toggle=0.
  - active becomes (wr_duration≠0).
  - Writing an active voice retriggers it. The superseded note produces no note_done.
  - wr_duration=0 deactivates the voice. No note_done is produced.
- **Phase counter** (per active voice, half_period≠0):
  - Counts 0..half_period-1.
  - At half_period-1 it wraps to 0 and flips toggle.
  - Tone period = 2·half_period clocks. half_period=1 toggles every clock.
  - With half_period=0 (rest) the counter holds and toggle stays 0.
- **Tick.**
  - The global prescaler counts 0..TICK_DIV-1 and wraps. tick is asserted in the cycle where it equals TICK_DIV-1.
  - On tick, each active voice decrements remaining.
  - If remaining==1 on tick: active←0, toggle←0, counter←0, and note_done[ch] pulses for exactly the next cycle.
  - The prescaler is not reset by writes. Note length is therefore between (dur-1)·TICK_DIV+1 and dur·TICK_DIV clocks.
- **Write/expiry collision** on the same voice in the same cycle: the write wins. The voice reloads and stays active, and no note_done is produced. Expiry on other voices proceeds normally.
- **Mixer.** sample = Σ over voices of (active & toggle ? volume : 0). The sum is PWM_W bits wide, with maximum NUM_CH·(2^VOL_W−1) < 2^PWM_W, so it cannot overflow.
- **PWM.**
  - The carrier is a free-running PWM_W-bit counter that wraps from 2^PWM_W−1 to 0.
  - level←sample when carrier==2^PWM_W−1, so each frame uses the sample captured at the end of the previous frame.
  - AUD_PWM←(carrier < level), registered.
  - Duty = level/2^PWM_W. level=0 gives AUD_PWM constantly 0.
- **Amplifier enable.** AUD_SD←|active, registered.
- **Outputs.** busy = active vector, driven directly from registers.

## Timing
- A write sampled at edge k: busy[ch]=1 after edge k.
  - First toggle rise at edge k+half_period, then toggles every half_period edges.
- AUD_SD follows busy with 1 cycle latency. It falls 1 cycle after the last voice goes inactive.
- Sample to AUD_PWM latency:
  - The sample is captured into level at the frame-boundary edge.
  - AUD_PWM reflects it from the next edge onward.
  - Full effect appears within 2^PWM_W+1 cycles of the toggle change.
- note_done is high for exactly 1 cycle, on the cycle after the expiring tick.
- Reset asserted mid-note: all outputs go to reset values immediately (asynchronously). No note_done pulse is produced.
- Simultaneous expiry of several voices on one tick: all corresponding note_done bits pulse in the same cycle.

## Test plan
Bench parameters: NUM_CH=4, VOL_W=4 (PWM_W=6), DIV_W=16, DUR_W=12, TICK_DIV=10.
- **Reset.** Pulse reset mid-note → busy=0, note_done=0, AUD_PWM=0, AUD_SD=0 immediately, and all stay 0 with no writes.
- **Single voice.** Write ch0 hp=5 vol=15 dur=3 → toggle period 10 clocks; level alternates 0/15; AUD_PWM high for 15 of 64 clocks in level-15 frames; busy[0] drops on the 3rd tick; note_done[0] one-cycle pulse; AUD_SD falls 1 cycle later.
- **Full mix.** Write all four voices hp=40 vol=15 dur=100 at the same phase → level=60 while toggles are high; AUD_PWM high 60 of 64 clocks; level=0 while toggles are low, with AUD_PWM all 0.
- **Collision.** Write ch1 in the exact cycle its remaining==1 tick occurs → busy[1] stays 1, note_done[1] stays 0, and the new duration runs fully.
- **Rest.** Write ch2 hp=0 vol=15 dur=2 → busy[2]=1, AUD_SD=1, level=0, AUD_PWM=0; note_done[2] on the 2nd tick.
- **Cancel.** Write ch3 dur=0 while it is playing → busy[3]=0 next cycle, no note_done[3]; when no voice is active, AUD_SD=0 one cycle later.
